// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : ID/EX hazard request and stage-control bundle for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_rs1_used;
  logic             ID_rs2_used;
  logic [4:0]       EX_rd;
  logic             EX_rd_wen;
  logic             EX_is_load;
  logic             EX_mdu_start;
  logic             MDU_done;
  logic             EX_br_taken;
  logic             MEM_rdata_vld;

  logic             HZ_stall_pc;
  logic             HZ_stall_id;
  logic             HZ_hold_ex;
  logic             HZ_bubble_ex;
  logic             HZ_flush_id;
  logic [1:0]       HZ_fwd_sel1;
  logic [1:0]       HZ_fwd_sel2;
  logic             HZ_err;
  logic [CNT_W-1:0] HZ_stall_cnt;

  // Pipeline side: reports stage contents, consumes stage controls.
  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    output EX_rd, EX_rd_wen, EX_is_load, EX_mdu_start,
    output MDU_done, EX_br_taken, MEM_rdata_vld,
    input  HZ_stall_pc, HZ_stall_id, HZ_hold_ex, HZ_bubble_ex, HZ_flush_id,
    input  HZ_fwd_sel1, HZ_fwd_sel2, HZ_err, HZ_stall_cnt
  );

  // Hazard controller side.
  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    input  EX_rd, EX_rd_wen, EX_is_load, EX_mdu_start,
    input  MDU_done, EX_br_taken, MEM_rdata_vld,
    output HZ_stall_pc, HZ_stall_id, HZ_hold_ex, HZ_bubble_ex, HZ_flush_id,
    output HZ_fwd_sel1, HZ_fwd_sel2, HZ_err, HZ_stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : RV32 pipeline hazard controller - load-use / MDU / branch
//               sequencing, operand forward selects, stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int LD_TMO = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int                 c_TMO_W    = (LD_TMO > 1) ? $clog2(LD_TMO) : 1;
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(LD_TMO - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;

  localparam logic [1:0] c_FWD_RF  = 2'b00;
  localparam logic [1:0] c_FWD_EX  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MDU_BUSY  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [4:0]         r_pend_rd;
  logic [c_TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic       w_match1;
  logic       w_match2;
  logic       w_pend_hit1;
  logic       w_pend_hit2;
  logic       w_stall;
  logic       w_hold;
  logic       w_bubble;
  logic       w_flush;
  logic       w_err;
  logic [1:0] w_fwd1;
  logic [1:0] w_fwd2;
  logic       w_pend_load;
  logic       w_tmo_inc;

  assign w_match1 = hz.ID_rs1_used & hz.EX_rd_wen & (hz.EX_rd != 5'd0) & (hz.EX_rd == hz.ID_rs1);
  assign w_match2 = hz.ID_rs2_used & hz.EX_rd_wen & (hz.EX_rd != 5'd0) & (hz.EX_rd == hz.ID_rs2);

  // Pending load destination seen by the instruction held in ID.
  assign w_pend_hit1 = hz.ID_rs1_used & (r_pend_rd != 5'd0) & (hz.ID_rs1 == r_pend_rd);
  assign w_pend_hit2 = hz.ID_rs2_used & (r_pend_rd != 5'd0) & (hz.ID_rs2 == r_pend_rd);

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_hold      = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_err       = 1'b0;
    w_fwd1      = c_FWD_RF;
    w_fwd2      = c_FWD_RF;
    w_pend_load = 1'b0;
    w_tmo_inc   = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (hz.EX_br_taken) begin
          w_flush  = 1'b1;
          w_bubble = 1'b1;
        end else if (hz.EX_mdu_start) begin
          w_stall     = 1'b1;
          w_hold      = 1'b1;
          w_state_nxt = ST_MDU_BUSY;
        end else if (hz.EX_is_load & (w_match1 | w_match2)) begin
          w_stall     = 1'b1;
          w_bubble    = 1'b1;
          w_pend_load = 1'b1;
          w_state_nxt = ST_LOAD_WAIT;
        end else begin
          w_fwd1 = (w_match1 & ~hz.EX_is_load) ? c_FWD_EX : c_FWD_RF;
          w_fwd2 = (w_match2 & ~hz.EX_is_load) ? c_FWD_EX : c_FWD_RF;
        end
      end

      ST_LOAD_WAIT: begin
        // EX holds a bubble here, so a concurrent mdu_start is not genuine.
        if (hz.MEM_rdata_vld) begin
          w_fwd1      = w_pend_hit1 ? c_FWD_MEM : c_FWD_RF;
          w_fwd2      = w_pend_hit2 ? c_FWD_MEM : c_FWD_RF;
          w_state_nxt = ST_RUN;
        end else begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (r_tmo == c_TMO_LAST) begin
            w_err       = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
      end

      ST_MDU_BUSY: begin
        if (hz.MDU_done) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_stall = 1'b1;
          w_hold  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_rd <= 5'd0;
      r_tmo     <= '0;
    end else if (w_pend_load) begin
      r_pend_rd <= hz.EX_rd;
      r_tmo     <= '0;
    end else if (w_tmo_inc) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Reset forces every control low at once, whatever the inputs show.
  assign hz.HZ_stall_pc  = rst_n & w_stall;
  assign hz.HZ_stall_id  = rst_n & w_stall;
  assign hz.HZ_hold_ex   = rst_n & w_hold;
  assign hz.HZ_bubble_ex = rst_n & w_bubble;
  assign hz.HZ_flush_id  = rst_n & w_flush;
  assign hz.HZ_err       = rst_n & w_err;
  assign hz.HZ_fwd_sel1  = rst_n ? w_fwd1 : c_FWD_RF;
  assign hz.HZ_fwd_sel2  = rst_n ? w_fwd2 : c_FWD_RF;
  assign hz.HZ_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl with a per-cycle
//               reference model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W  = 6;
  localparam int LD_TMO = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W), .LD_TMO(LD_TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: what the pipeline is waiting for, not how the DUT encodes it.
  typedef struct packed {
    logic       stall;
    logic       hold;
    logic       bubble;
    logic       flush;
    logic       err;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  bit         m_load_pending = 1'b0;
  bit         m_mdu_pending  = 1'b0;
  logic [4:0] m_pend_rd      = 5'd0;
  int         m_waited       = 0;
  int         m_cnt          = 0;
  exp_t       e_cur          = '0;

  function automatic logic ex_feeds(input logic [4:0] rs, input logic used);
    return used && hz.EX_rd_wen && (hz.EX_rd != 5'd0) && (hz.EX_rd == rs);
  endfunction

  function automatic exp_t expect_out();
    exp_t e;
    logic h1;
    logic h2;
    e  = '0;
    h1 = ex_feeds(hz.ID_rs1, hz.ID_rs1_used);
    h2 = ex_feeds(hz.ID_rs2, hz.ID_rs2_used);
    if (!rst_n) return e;
    if (m_load_pending) begin
      if (hz.MEM_rdata_vld) begin
        e.f1 = (hz.ID_rs1_used && m_pend_rd != 0 && hz.ID_rs1 == m_pend_rd) ? 2'b10 : 2'b00;
        e.f2 = (hz.ID_rs2_used && m_pend_rd != 0 && hz.ID_rs2 == m_pend_rd) ? 2'b10 : 2'b00;
      end else begin
        e.stall  = 1'b1;
        e.bubble = 1'b1;
        e.err    = (m_waited == LD_TMO - 1);
      end
    end else if (m_mdu_pending) begin
      e.stall = !hz.MDU_done;
      e.hold  = !hz.MDU_done;
    end else if (hz.EX_br_taken) begin
      e.flush  = 1'b1;
      e.bubble = 1'b1;
    end else if (hz.EX_mdu_start) begin
      e.stall = 1'b1;
      e.hold  = 1'b1;
    end else if (hz.EX_is_load && (h1 || h2)) begin
      e.stall  = 1'b1;
      e.bubble = 1'b1;
    end else begin
      e.f1 = (h1 && !hz.EX_is_load) ? 2'b01 : 2'b00;
      e.f2 = (h2 && !hz.EX_is_load) ? 2'b01 : 2'b00;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load_pending <= 1'b0;
      m_mdu_pending  <= 1'b0;
      m_pend_rd      <= 5'd0;
      m_waited       <= 0;
      m_cnt          <= 0;
    end else begin
      if (e_cur.stall && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (m_load_pending) begin
        if (hz.MEM_rdata_vld || m_waited == LD_TMO - 1) m_load_pending <= 1'b0;
        else m_waited <= m_waited + 1;
      end else if (m_mdu_pending) begin
        if (hz.MDU_done) m_mdu_pending <= 1'b0;
      end else if (!hz.EX_br_taken) begin
        if (hz.EX_mdu_start) begin
          m_mdu_pending <= 1'b1;
        end else if (hz.EX_is_load &&
                     (ex_feeds(hz.ID_rs1, hz.ID_rs1_used) || ex_feeds(hz.ID_rs2, hz.ID_rs2_used))) begin
          m_load_pending <= 1'b1;
          m_pend_rd      <= hz.EX_rd;
          m_waited       <= 0;
        end
      end
    end
  end

  // Inputs change only at negedge; outputs are compared 3 ns later.
  initial forever begin
    @(negedge clk);
    #3;
    e_cur = expect_out();
    check("stall_pc",  hz.HZ_stall_pc,  e_cur.stall);
    check("stall_id",  hz.HZ_stall_id,  e_cur.stall);
    check("hold_ex",   hz.HZ_hold_ex,   e_cur.hold);
    check("bubble_ex", hz.HZ_bubble_ex, e_cur.bubble);
    check("flush_id",  hz.HZ_flush_id,  e_cur.flush);
    check("err",       hz.HZ_err,       e_cur.err);
    check("fwd_sel1",  hz.HZ_fwd_sel1,  e_cur.f1);
    check("fwd_sel2",  hz.HZ_fwd_sel2,  e_cur.f2);
    check("stall_cnt", hz.HZ_stall_cnt, m_cnt);
  end

  task automatic idle_in();
    hz.ID_rs1        = 5'd0;
    hz.ID_rs2        = 5'd0;
    hz.ID_rs1_used   = 1'b0;
    hz.ID_rs2_used   = 1'b0;
    hz.EX_rd         = 5'd0;
    hz.EX_rd_wen     = 1'b0;
    hz.EX_is_load    = 1'b0;
    hz.EX_mdu_start  = 1'b0;
    hz.MDU_done      = 1'b0;
    hz.EX_br_taken   = 1'b0;
    hz.MEM_rdata_vld = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
    idle_in();
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic load_use_rs1(input logic [4:0] rd);
    hz.EX_is_load  = 1'b1;
    hz.EX_rd       = rd;
    hz.EX_rd_wen   = 1'b1;
    hz.ID_rs1      = rd;
    hz.ID_rs1_used = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("rst_stall_pc", hz.HZ_stall_pc, 1'b0);
    check("rst_cnt", hz.HZ_stall_cnt, 0);

    // Load-use: data arrives on the second wait cycle.
    do_reset();
    nxt(); load_use_rs1(5'd5);
    #3; check("lu_stall0", hz.HZ_stall_pc, 1'b1); check("lu_bubble0", hz.HZ_bubble_ex, 1'b1);
    nxt(); hz.ID_rs1 = 5'd5; hz.ID_rs1_used = 1'b1;
    #3; check("lu_stall1", hz.HZ_stall_pc, 1'b1);
    nxt(); hz.ID_rs1 = 5'd5; hz.ID_rs1_used = 1'b1; hz.MEM_rdata_vld = 1'b1;
    #3; check("lu_fwd1", hz.HZ_fwd_sel1, 2'b10); check("lu_stall_vld", hz.HZ_stall_pc, 1'b0);
    nxt();
    #3; check("lu_cnt", hz.HZ_stall_cnt, 2);

    // Back-to-back ALU forwarding and x0 / unused-operand cases.
    nxt(); hz.EX_rd = 5'd7; hz.EX_rd_wen = 1'b1; hz.ID_rs2 = 5'd7; hz.ID_rs2_used = 1'b1;
           hz.ID_rs1 = 5'd3; hz.ID_rs1_used = 1'b1;
    #3; check("alu_fwd2", hz.HZ_fwd_sel2, 2'b01); check("alu_fwd1", hz.HZ_fwd_sel1, 2'b00);
    nxt(); hz.EX_rd_wen = 1'b1; hz.ID_rs1_used = 1'b1; hz.ID_rs2_used = 1'b1;
    #3; check("x0_fwd1", hz.HZ_fwd_sel1, 2'b00); check("x0_fwd2", hz.HZ_fwd_sel2, 2'b00);
    nxt(); hz.EX_rd = 5'd9; hz.EX_rd_wen = 1'b1; hz.ID_rs1 = 5'd9;
    #3; check("unused_fwd1", hz.HZ_fwd_sel1, 2'b00);
    nxt(); hz.EX_is_load = 1'b1; hz.EX_rd = 5'd12; hz.EX_rd_wen = 1'b1;
           hz.ID_rs2 = 5'd12; hz.ID_rs2_used = 1'b1;
    #3; check("lu2_stall", hz.HZ_stall_pc, 1'b1);
    nxt(); hz.ID_rs2 = 5'd12; hz.ID_rs2_used = 1'b1; hz.ID_rs1 = 5'd12; hz.MEM_rdata_vld = 1'b1;
    #3; check("lu2_fwd2", hz.HZ_fwd_sel2, 2'b10); check("lu2_fwd1", hz.HZ_fwd_sel1, 2'b00);

    // MDU: done 33 cycles after start.
    do_reset();
    nxt(); hz.EX_mdu_start = 1'b1;
    #3; check("mdu_hold0", hz.HZ_hold_ex, 1'b1);
    repeat (32) nxt();
    nxt(); hz.MDU_done = 1'b1;
    #3; check("mdu_hold_done", hz.HZ_hold_ex, 1'b0); check("mdu_stall_done", hz.HZ_stall_pc, 1'b0);
    nxt(); hz.MDU_done = 1'b1;
    #3; check("mdu_done_run", hz.HZ_stall_pc, 1'b0); check("mdu_cnt", hz.HZ_stall_cnt, 33);

    // Taken branch beats a simultaneous load-use and a simultaneous mdu_start.
    nxt(); load_use_rs1(5'd5); hz.EX_br_taken = 1'b1;
    #3; check("br_flush", hz.HZ_flush_id, 1'b1); check("br_bubble", hz.HZ_bubble_ex, 1'b1);
        check("br_stall", hz.HZ_stall_pc, 1'b0);
    nxt();
    #3; check("br_after", hz.HZ_stall_pc, 1'b0);
    nxt(); hz.EX_br_taken = 1'b1; hz.EX_mdu_start = 1'b1;
    #3; check("br_mdu_hold", hz.HZ_hold_ex, 1'b0);
    nxt();
    #3; check("br_mdu_after", hz.HZ_hold_ex, 1'b0);

    // Load timeout: error on the 4th wait cycle, stalls gone the cycle after.
    do_reset();
    nxt(); load_use_rs1(5'd5);
    for (int k = 1; k <= LD_TMO; k++) begin
      nxt(); hz.ID_rs1 = 5'd5; hz.ID_rs1_used = 1'b1;
      #3; check("tmo_err", hz.HZ_err, (k == LD_TMO)); check("tmo_stall", hz.HZ_stall_pc, 1'b1);
    end
    nxt(); hz.ID_rs1 = 5'd5; hz.ID_rs1_used = 1'b1;
    #3; check("tmo_drop", hz.HZ_stall_pc, 1'b0); check("tmo_err_gone", hz.HZ_err, 1'b0);

    // Data valid and mdu_start together while waiting: the load wins.
    nxt(); load_use_rs1(5'd8);
    nxt(); hz.MEM_rdata_vld = 1'b1; hz.EX_mdu_start = 1'b1;
    #3; check("vld_mdu_hold", hz.HZ_hold_ex, 1'b0);
    nxt();
    #3; check("vld_mdu_run", hz.HZ_stall_pc, 1'b0);

    // Counter saturation.
    do_reset();
    nxt(); hz.EX_mdu_start = 1'b1;
    repeat (69) nxt();
    nxt(); hz.MDU_done = 1'b1;
    #3; check("cnt_sat", hz.HZ_stall_cnt, CNT_MAX);

    // Asynchronous reset in the middle of an MDU stall.
    nxt(); hz.EX_mdu_start = 1'b1;
    repeat (3) nxt();
    #1 rst_n = 1'b0;
    #2; check("rmid_stall", hz.HZ_stall_pc, 1'b0); check("rmid_hold", hz.HZ_hold_ex, 1'b0);
        check("rmid_cnt", hz.HZ_stall_cnt, 0);
    nxt(); rst_n = 1'b1;
    nxt();
    #3; check("rmid_run", hz.HZ_stall_pc, 1'b0); check("rmid_cnt_after", hz.HZ_stall_cnt, 0);

    nxt();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
